multicycle_controller: RTL

Main control FSM for the multi-cycle RV32I core. It sequences one shared ALU, one shared memory port and the register file across FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK steps. It drives the 2-bit ALUOp consumed by alu_decoder and all datapath mux selects and write enables. Memory accesses stall on a ready handshake, and unsupported opcodes trap.

---
 rtl/riscv_ctrl_pkg.sv | 71 +++++++
 rtl/multicycle_controller.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, mux selects and FSM states.
package riscv_ctrl_pkg;

    localparam int unsigned OP_W = 7;

    localparam logic [OP_W-1:0] OP_LW    = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW    = 7'b0100011;
    localparam logic [OP_W-1:0] OP_RTYPE = 7'b0110011;
    localparam logic [OP_W-1:0] OP_IALU  = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BEQ   = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL   = 7'b1101111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RD1   = 2'b10
    } src_a_e;

    typedef enum logic [1:0] {
        SRCB_RD2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } src_b_e;

    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'b00,
        RES_DATA      = 2'b01,
        RES_ALURESULT = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_e;

    // Immediate format is a pure function of the opcode; unknown opcodes fall back to I.
    function automatic imm_src_e imm_src_of(input logic [OP_W-1:0] op);
        imm_src_e imm;
        case (op)
            OP_SW:   imm = IMM_S;
            OP_BEQ:  imm = IMM_B;
            OP_JAL:  imm = IMM_J;
            default: imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RV32I core: sequences the shared ALU, memory port and register file.
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] op,
    input  logic            zero,
    input  logic            mem_ready,
    output logic [1:0]      ALUOp,
    output logic [1:0]      ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [1:0]      ResultSrc,
    output logic [1:0]      ImmSrc,
    output logic            AdrSrc,
    output logic            IRWrite,
    output logic            PCWrite,
    output logic            RegWrite,
    output logic            MemWrite,
    output logic            illegal
);

    state_e      state_q;
    state_e      state_d;
    alu_op_e     alu_op_c;
    src_a_e      src_a_c;
    src_b_e      src_b_c;
    result_src_e result_src_c;
    logic        adr_src_c;
    logic        ir_write_c;
    logic        pc_update_c;
    logic        branch_c;
    logic        reg_write_c;
    logic        mem_write_c;
    logic        illegal_c;

    // State register; reset parks the FSM in FETCH without waiting for a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state datapath controls.
    always_comb begin
        state_d      = state_q;
        alu_op_c     = ALUOP_ADD;
        src_a_c      = SRCA_PC;
        src_b_c      = SRCB_RD2;
        result_src_c = RES_ALUOUT;
        adr_src_c    = 1'b0;
        ir_write_c   = 1'b0;
        pc_update_c  = 1'b0;
        branch_c     = 1'b0;
        reg_write_c  = 1'b0;
        mem_write_c  = 1'b0;
        illegal_c    = 1'b0;

        case (state_q)
            S_FETCH: begin
                src_b_c      = SRCB_FOUR;
                result_src_c = RES_ALURESULT;
                ir_write_c   = mem_ready;
                pc_update_c  = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // ALU precomputes OldPC + imm so BEQ can use it as the branch target.
                src_a_c = SRCA_OLDPC;
                src_b_c = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECR;
                    OP_IALU:      state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                src_a_c = SRCA_RD1;
                src_b_c = SRCB_IMM;
                state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src_c = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                result_src_c = RES_DATA;
                reg_write_c  = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src_c   = 1'b1;
                mem_write_c = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_EXECR: begin
                src_a_c  = SRCA_RD1;
                src_b_c  = SRCB_RD2;
                alu_op_c = ALUOP_FUNCT;
                state_d  = S_ALUWB;
            end
            S_EXECI: begin
                src_a_c  = SRCA_RD1;
                src_b_c  = SRCB_IMM;
                alu_op_c = ALUOP_FUNCT;
                state_d  = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_BEQ: begin
                src_a_c  = SRCA_RD1;
                src_b_c  = SRCB_RD2;
                alu_op_c = ALUOP_SUB;
                branch_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_JAL: begin
                // PC takes the target from ALUOut while the ALU forms OldPC+4 for the link write.
                src_a_c     = SRCA_OLDPC;
                src_b_c     = SRCB_FOUR;
                pc_update_c = 1'b1;
                state_d     = S_ALUWB;
            end
            S_TRAP: begin
                illegal_c = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign ALUOp     = alu_op_c;
    assign ALUSrcA   = src_a_c;
    assign ALUSrcB   = src_b_c;
    assign ResultSrc = result_src_c;
    assign ImmSrc    = imm_src_of(op);
    assign AdrSrc    = adr_src_c;

    // Enables are masked by reset so FETCH's mem_ready-driven strobes stay low while reset is held.
    assign IRWrite  = ir_write_c & rst;
    assign PCWrite  = (pc_update_c | (branch_c & zero)) & rst;
    assign RegWrite = reg_write_c & rst;
    assign MemWrite = mem_write_c & rst;
    assign illegal  = illegal_c & rst;

endmodule
